// File: rtl/conv_loop_if.sv
// conv_loop_if: control, handshake and index bundle between the loop sequencer and its consumer.
interface conv_loop_if #(parameter int CW = 4);
  logic start, abort, out_ready, out_valid, first, last, busy, done;
  logic [CW-1:0] kx, ky, ox, oy;
  modport master (input start, abort, out_ready,
                  output out_valid, kx, ky, ox, oy, first, last, busy, done);
  modport slave  (output start, abort, out_ready,
                  input out_valid, kx, ky, ox, oy, first, last, busy, done);
endinterface

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: walks kx/ky/ox/oy for one convolution tile, one index beat per handshake.
module conv_loop_ctrl #(
  parameter int KW = 3,
  parameter int KH = 3,
  parameter int OW = 8,
  parameter int OH = 8,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst,
  conv_loop_if.master m
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] kx, ky, ox, oy;
  logic run, acc, kx_end, ky_end, ox_end, oy_end, fin;
  assign run    = state == RUN;
  assign acc    = run && m.out_ready && !m.abort;
  assign kx_end = kx == CW'(KW - 1);
  assign ky_end = ky == CW'(KH - 1);
  assign ox_end = ox == CW'(OW - 1);
  assign oy_end = oy == CW'(OH - 1);
  assign fin    = kx_end && ky_end && ox_end && oy_end;
  always_comb begin
    state_nx    = state;
    if (state == IDLE && m.start) state_nx = RUN;
    if (run && (m.abort || (acc && fin))) state_nx = m.abort ? IDLE : DONE;
    if (state == DONE) state_nx = IDLE;
    m.out_valid = run;
    m.kx        = kx;
    m.ky        = ky;
    m.ox        = ox;
    m.oy        = oy;
    m.first     = run && kx == '0 && ky == '0;
    m.last      = run && kx_end && ky_end;
    m.busy      = state != IDLE;
    m.done      = state == DONE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // Each counter wraps to 0 at its max, so the final beat naturally returns all indices to 0.
  always_ff @(posedge clk) begin
    if (rst || (run && m.abort)) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (acc) begin
      kx <= kx_end ? '0 : kx + 1'b1;
      if (kx_end) ky <= ky_end ? '0 : ky + 1'b1;
      if (kx_end && ky_end) ox <= ox_end ? '0 : ox + 1'b1;
      if (kx_end && ky_end && ox_end) oy <= oy_end ? '0 : oy + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: randomized/directed stimulus with a queue scoreboard fed by a tile model.
module tb_conv_loop_ctrl;
  localparam int KW = 3, KH = 3, OW = 2, OH = 2, CW = 4;
  localparam int TOTAL = KW * KH * OW * OH;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  conv_loop_if #(.CW(CW)) m();
  conv_loop_if #(.CW(1)) d();
  conv_loop_ctrl #(.KW(KW), .KH(KH), .OW(OW), .OH(OH), .CW(CW)) dut (.clk(clk), .rst(rst), .m(m));
  conv_loop_ctrl #(.KW(1), .KH(1), .OW(1), .OH(1), .CW(1)) dut1 (.clk(clk), .rst(rst), .m(d));
  int checks = 0;
  int errors = 0;
  logic [18:0] q[$];
  logic [18:0] e_pop;
  bit active = 0;
  bit exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tile: every beat in loop order, entry = {kx,ky,ox,oy,first,last,final}.
  task automatic push_tile();
    for (int y = 0; y < OH; y++)
      for (int x = 0; x < OW; x++)
        for (int j = 0; j < KH; j++)
          for (int i = 0; i < KW; i++)
            q.push_back({CW'(i), CW'(j), CW'(x), CW'(y), i == 0 && j == 0,
                         i == KW - 1 && j == KH - 1,
                         i == KW - 1 && j == KH - 1 && x == OW - 1 && y == OH - 1});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      active   = 0;
      exp_done = 0;
    end else begin
      check("done", m.done, exp_done);
      check("valid", m.out_valid, active && !exp_done);
      check("busy", m.busy, active);
      if (active && !exp_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat got valid=%0b want no beat (queue empty)", m.out_valid);
        end else
          check("beat", {m.kx, m.ky, m.ox, m.oy, m.first, m.last}, q[0][18:1]);
      end else if (!active)
        check("idle_outs", {m.kx, m.ky, m.ox, m.oy, m.first, m.last}, 0);
      if (exp_done) begin
        active   = 0;
        exp_done = 0;
      end else if (active && m.abort) begin
        q.delete();
        active = 0;
      end else if (active && m.out_ready) begin
        if (q.size() > 0) begin
          e_pop    = q.pop_front();
          exp_done = e_pop[0];
        end
      end else if (!active && m.start) begin
        push_tile();
        active = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 stall at beat 4, 2 stray starts, 3 abort at 20, 4 rst at 15, 5 random
  task automatic run_tile(input int mode, input int exp_cyc, input int exp_beats);
    int n = 0;
    int nb = 0;
    int stall = 0;
    bit got_done = 0;
    bit fired = 0;
    bit fin = 0;
    tick();
    m.start = 1;
    tick();
    while (!fin && n < 1000) begin
      m.start = 0;
      m.abort = 0;
      m.out_ready = 1;
      rst = 0;
      if (mode == 1 && nb == 4 && stall < 5) begin
        m.out_ready = 0;
        stall++;
      end
      if (mode == 2 && ((nb == 10 && !fired) || nb == TOTAL)) begin
        m.start = 1;
        fired = 1;
      end
      if (mode == 3 && nb == 20 && !fired) begin
        m.abort = 1;
        fired = 1;
      end
      if (mode == 4 && nb == 15 && !fired) begin
        m.out_ready = 0;
        rst = 1;
        fired = 1;
      end
      if (mode == 5) begin
        m.out_ready = $urandom_range(0, 2) != 0;
        m.start = $urandom_range(0, 9) == 0;
      end
      @(negedge clk);
      n++;
      if (m.out_valid && m.out_ready && !m.abort && !rst) nb++;
      if (m.done) begin
        got_done = 1;
        fin = 1;
      end
      if ((mode == 3 || mode == 4) && fired && !m.abort && !rst) fin = 1;
      if (!fin) tick();
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL timeout mode %0d got %0d cycles want done", mode, n);
    end
    if (mode <= 2) check("latency", n, exp_cyc);
    check("beats", nb, exp_beats);
    check("done_seen", got_done, mode != 3 && mode != 4);
  endtask

  initial begin
    m.start = 0; m.abort = 0; m.out_ready = 0;
    d.start = 0; d.abort = 0; d.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {m.out_valid, m.busy, m.done, m.first, m.last}, 0);
    check("rst_idx", {m.kx, m.ky, m.ox, m.oy}, 0);
    check("rst_ctl1", {d.out_valid, d.busy, d.done, d.first, d.last}, 0);
    tick();
    rst = 0;
    run_tile(0, TOTAL + 1, TOTAL);
    run_tile(1, TOTAL + 6, TOTAL);
    run_tile(2, TOTAL + 1, TOTAL);
    run_tile(0, TOTAL + 1, TOTAL);
    run_tile(3, 0, 20);
    run_tile(0, TOTAL + 1, TOTAL);
    run_tile(4, 0, 15);
    run_tile(0, TOTAL + 1, TOTAL);
    repeat (4) run_tile(5, 0, TOTAL);
    tick();
    m.start = 0;
    d.start = 1;
    d.out_ready = 1;
    tick();
    d.start = 0;
    @(negedge clk);
    check("deg_beat", {d.out_valid, d.first, d.last, d.kx, d.done}, 5'b11100);
    @(negedge clk);
    check("deg_done", {d.done, d.out_valid, d.busy}, 3'b101);
    @(negedge clk);
    check("deg_idle", {d.done, d.out_valid, d.busy}, 3'b000);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish by 200000");
    $fatal(1);
  end
endmodule
